// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of one SRAM_interface.
// Accepted requests are registered onto the SRAM-side outputs. A tag pipeline
// routes each read's d_out back to its requester READ_LAT cycles after acceptance.
// Build option: define SRAM_ARB_FIXED_PRIO_EN to give port 0 fixed priority on conflicts.
module sram_port_arbiter #(
  parameter int unsigned READ_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        valid_0,
  input  logic        valid_1,
  input  logic        we_0,
  input  logic        we_1,
  input  logic [8:0]  addr_0,
  input  logic [8:0]  addr_1,
  input  logic [1:0]  addr_2_4_0,
  input  logic [1:0]  addr_2_4_1,
  input  logic [2:0]  addr_3_8_0,
  input  logic [2:0]  addr_3_8_1,
  input  logic [2:0]  conf_0,
  input  logic [2:0]  conf_1,
  input  logic [31:0] wdata_0,
  input  logic [31:0] wdata_1,
  output logic        ready_0,
  output logic        ready_1,
  output logic        rvalid_0,
  output logic        rvalid_1,
  output logic [31:0] rdata_0,
  output logic [31:0] rdata_1,
  output logic        csb,
  output logic        web,
  output logic [8:0]  addr,
  output logic [1:0]  addr_2_4,
  output logic [2:0]  addr_3_8,
  output logic [2:0]  conf,
  output logic [31:0] d_fabric,
  input  logic [31:0] d_out
);

  logic        last_grant_q, last_grant_d;
  logic        csb_q, csb_d;
  logic        web_q, web_d;
  logic [8:0]  addr_q, addr_d;
  logic [1:0]  addr_2_4_q, addr_2_4_d;
  logic [2:0]  addr_3_8_q, addr_3_8_d;
  logic [2:0]  conf_q, conf_d;
  logic [31:0] d_fabric_q, d_fabric_d;
  logic [READ_LAT-1:0] tag_rd_q, tag_rd_d;
  logic [READ_LAT-1:0] tag_port_q, tag_port_d;
  logic        rvalid_0_q, rvalid_0_d;
  logic        rvalid_1_q, rvalid_1_d;
  logic        acc_0, acc_1;
  logic        rd_in, port_in;

  // Grant decision from this cycle's requests; at most one ready is ever high.
  always_comb begin
    ready_0 = 1'b0;
    ready_1 = 1'b0;
    if (!hold) begin
      if (valid_0 && valid_1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        ready_0 = 1'b1;
`else
        // Port that was not granted last time wins the conflict.
        ready_0 = last_grant_q;
        ready_1 = ~last_grant_q;
`endif
      end else begin
        ready_0 = valid_0;
        ready_1 = valid_1;
      end
    end
  end

  assign acc_0   = valid_0 & ready_0;
  assign acc_1   = valid_1 & ready_1;
  assign rd_in   = (acc_0 & ~we_0) | (acc_1 & ~we_1);
  assign port_in = acc_1 & ~we_1;

  // Next-state for the SRAM-side registers, grant history and read tags.
  always_comb begin
    last_grant_d = last_grant_q;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    addr_d       = addr_q;
    addr_2_4_d   = addr_2_4_q;
    addr_3_8_d   = addr_3_8_q;
    conf_d       = conf_q;
    d_fabric_d   = d_fabric_q;
    if (acc_1) begin
      last_grant_d = 1'b1;
      csb_d        = 1'b0;
      web_d        = ~we_1;
      addr_d       = addr_1;
      addr_2_4_d   = addr_2_4_1;
      addr_3_8_d   = addr_3_8_1;
      conf_d       = conf_1;
      d_fabric_d   = wdata_1;
    end else if (acc_0) begin
      last_grant_d = 1'b0;
      csb_d        = 1'b0;
      web_d        = ~we_0;
      addr_d       = addr_0;
      addr_2_4_d   = addr_2_4_0;
      addr_3_8_d   = addr_3_8_0;
      conf_d       = conf_0;
      d_fabric_d   = wdata_0;
    end
    tag_rd_d   = {tag_rd_q[READ_LAT-2:0], rd_in};
    tag_port_d = {tag_port_q[READ_LAT-2:0], port_in};
    // Extra register stage puts rvalid exactly READ_LAT cycles after acceptance.
    rvalid_0_d = tag_rd_q[READ_LAT-1] & ~tag_port_q[READ_LAT-1];
    rvalid_1_d = tag_rd_q[READ_LAT-1] & tag_port_q[READ_LAT-1];
  end

  // State registers; reset drops all in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      addr_q       <= '0;
      addr_2_4_q   <= '0;
      addr_3_8_q   <= '0;
      conf_q       <= '0;
      d_fabric_q   <= '0;
      tag_rd_q     <= '0;
      tag_port_q   <= '0;
      rvalid_0_q   <= 1'b0;
      rvalid_1_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      addr_q       <= addr_d;
      addr_2_4_q   <= addr_2_4_d;
      addr_3_8_q   <= addr_3_8_d;
      conf_q       <= conf_d;
      d_fabric_q   <= d_fabric_d;
      tag_rd_q     <= tag_rd_d;
      tag_port_q   <= tag_port_d;
      rvalid_0_q   <= rvalid_0_d;
      rvalid_1_q   <= rvalid_1_d;
    end
  end

  assign csb      = csb_q;
  assign web      = web_q;
  assign addr     = addr_q;
  assign addr_2_4 = addr_2_4_q;
  assign addr_3_8 = addr_3_8_q;
  assign conf     = conf_q;
  assign d_fabric = d_fabric_q;
  assign rvalid_0 = rvalid_0_q;
  assign rvalid_1 = rvalid_1_q;
  assign rdata_0  = rvalid_0_q ? d_out : 32'h0;
  assign rdata_1  = rvalid_1_q ? d_out : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a response scoreboard.
// Honours SRAM_ARB_FIXED_PRIO_EN for the conflict-arbitration expectations.
module tb_sram_port_arbiter;
  localparam int unsigned READ_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n, hold;
  logic        valid_0, valid_1, we_0, we_1;
  logic [8:0]  addr_0, addr_1;
  logic [1:0]  addr_2_4_0, addr_2_4_1;
  logic [2:0]  addr_3_8_0, addr_3_8_1, conf_0, conf_1;
  logic [31:0] wdata_0, wdata_1;
  logic        ready_0, ready_1, rvalid_0, rvalid_1;
  logic [31:0] rdata_0, rdata_1;
  logic        csb, web;
  logic [8:0]  addr;
  logic [1:0]  addr_2_4;
  logic [2:0]  addr_3_8, conf;
  logic [31:0] d_fabric, d_out;

  always #5 clk = ~clk;

  sram_port_arbiter #(.READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .valid_0(valid_0), .valid_1(valid_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1),
    .addr_2_4_0(addr_2_4_0), .addr_2_4_1(addr_2_4_1),
    .addr_3_8_0(addr_3_8_0), .addr_3_8_1(addr_3_8_1),
    .conf_0(conf_0), .conf_1(conf_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .ready_0(ready_0), .ready_1(ready_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .csb(csb), .web(web), .addr(addr),
    .addr_2_4(addr_2_4), .addr_3_8(addr_3_8), .conf(conf), .d_fabric(d_fabric),
    .d_out(d_out)
  );

  typedef struct {int due; logic port;} rsp_t;
  rsp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic        exp_csb, exp_web;
  logic [8:0]  exp_addr;
  logic [1:0]  exp_a24;
  logic [2:0]  exp_a38, exp_conf;
  logic [31:0] exp_dfab;
  logic        dout_ovr_en = 1'b0;
  logic [31:0] dout_ovr = 32'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic reset_exp();
    exp_csb  = 1'b1;
    exp_web  = 1'b1;
    exp_addr = '0;
    exp_a24  = '0;
    exp_a38  = '0;
    exp_conf = '0;
    exp_dfab = '0;
    sb.delete();
  endtask

  // Compare SRAM-side outputs and pop any response due this cycle.
  task automatic check_outputs();
    logic ev0, ev1;
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (sb[0].port) ev1 = 1'b1;
      else ev0 = 1'b1;
      void'(sb.pop_front());
    end
    chk("csb", 32'(csb), 32'(exp_csb));
    chk("web", 32'(web), 32'(exp_web));
    chk("addr", 32'(addr), 32'(exp_addr));
    chk("addr_2_4", 32'(addr_2_4), 32'(exp_a24));
    chk("addr_3_8", 32'(addr_3_8), 32'(exp_a38));
    chk("conf", 32'(conf), 32'(exp_conf));
    chk("d_fabric", d_fabric, exp_dfab);
    chk("rvalid_0", 32'(rvalid_0), 32'(ev0));
    chk("rvalid_1", 32'(rvalid_1), 32'(ev1));
    chk("rdata_0", rdata_0, ev0 ? d_out : 32'h0);
    chk("rdata_1", rdata_1, ev1 ? d_out : 32'h0);
  endtask

  // One clock: check readies, predict the edge, then check registered outputs.
  task automatic step(input logic er0, input logic er1);
    logic a0, a1;
    #1;
    chk("ready_0", 32'(ready_0), 32'(er0));
    chk("ready_1", 32'(ready_1), 32'(er1));
    a0 = valid_0 & er0;
    a1 = valid_1 & er1;
    if (a1) begin
      exp_csb = 1'b0; exp_web = ~we_1; exp_addr = addr_1; exp_a24 = addr_2_4_1;
      exp_a38 = addr_3_8_1; exp_conf = conf_1; exp_dfab = wdata_1;
      if (!we_1) sb.push_back('{cyc + 1 + int'(READ_LAT), 1'b1});
    end else if (a0) begin
      exp_csb = 1'b0; exp_web = ~we_0; exp_addr = addr_0; exp_a24 = addr_2_4_0;
      exp_a38 = addr_3_8_0; exp_conf = conf_0; exp_dfab = wdata_0;
      if (!we_0) sb.push_back('{cyc + 1 + int'(READ_LAT), 1'b0});
    end else begin
      exp_csb = 1'b1;
      exp_web = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
    d_out = dout_ovr_en ? dout_ovr : (32'h5A00_0000 | 32'(cyc));
    #1;
    check_outputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; hold = 1'b0; d_out = 32'h0;
    valid_0 = 1'b0; valid_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
    addr_0 = '0; addr_1 = '0; addr_2_4_0 = '0; addr_2_4_1 = '0;
    addr_3_8_0 = '0; addr_3_8_1 = '0; conf_0 = '0; conf_1 = '0;
    wdata_0 = '0; wdata_1 = '0;
    reset_exp();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    #1;

    // Port 0 write, then idle: csb pulses low for one cycle, no response.
    valid_0 = 1'b1; we_0 = 1'b1; addr_0 = 9'h005; conf_0 = 3'b101;
    addr_2_4_0 = 2'd1; addr_3_8_0 = 3'd2; wdata_0 = 32'hDEAD_BEEF;
    step(1'b1, 1'b0);
    valid_0 = 1'b0;
    repeat (2) step(1'b0, 1'b0);

    // Port 1 read; SRAM returns DEADBEEF.
    dout_ovr_en = 1'b1; dout_ovr = 32'hDEAD_BEEF;
    valid_1 = 1'b1; we_1 = 1'b0; addr_1 = 9'h005; conf_1 = 3'b010;
    addr_2_4_1 = 2'd2; addr_3_8_1 = 3'd4; wdata_1 = 32'h1111_2222;
    step(1'b0, 1'b1);
    valid_1 = 1'b0;
    repeat (READ_LAT + 1) step(1'b0, 1'b0);
    dout_ovr_en = 1'b0;

    // Both ports continuously requesting reads.
    valid_0 = 1'b1; we_0 = 1'b0; addr_0 = 9'h0A0; conf_0 = 3'b001;
    valid_1 = 1'b1; we_1 = 1'b0; addr_1 = 9'h150; conf_1 = 3'b110;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    repeat (4) step(1'b1, 1'b0);
`else
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
`endif
    valid_0 = 1'b0; valid_1 = 1'b0;
    repeat (READ_LAT + 1) step(1'b0, 1'b0);

    // Read accepted just before hold still returns; hold blocks new grants.
    valid_0 = 1'b1; we_0 = 1'b0; addr_0 = 9'h1AB;
    step(1'b1, 1'b0);
    hold = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    hold = 1'b0; valid_0 = 1'b0;
    step(1'b0, 1'b0);

    // Reset while a read is in flight: outputs clear at once, response lost.
    valid_1 = 1'b1; we_1 = 1'b0; addr_1 = 9'h0F0;
    step(1'b0, 1'b1);
    valid_1 = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_exp();
    check_outputs();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    repeat (10) step(1'b0, 1'b0);

    // Grant history was reset: port 0 wins the first conflict.
    valid_0 = 1'b1; valid_1 = 1'b1; we_0 = 1'b0; we_1 = 1'b0;
    step(1'b1, 1'b0);
    valid_0 = 1'b0; valid_1 = 1'b0;
    repeat (READ_LAT + 1) step(1'b0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM_interface between two fabric requesters (port 0, port 1) using round-robin arbitration with a valid/ready request handshake.
- Issues at most one access per cycle to the interface through registered outputs.
- Tracks in-flight reads in a tag pipeline and returns d_out to the requester that issued each read, after a fixed latency.
- Sits between the fabric-side masters and SRAM_interface in the hierarchical SRAM cluster.

Parameters:
- READ_LAT, 3, cycles from the request acceptance edge to the cycle rvalid is asserted (2 to 8 legal).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  high = no new grants (e.g. during reconfiguration); in-flight reads still complete
- valid_0, valid_1  input  1  request valid per port
- we_0, we_1  input  1  1 = write, 0 = read
- addr_0, addr_1  input  9  word address
- addr_2_4_0, addr_2_4_1  input  2  unit select
- addr_3_8_0, addr_3_8_1  input  3  sub-word select
- conf_0, conf_1  input  3  width configuration code
- wdata_0, wdata_1  input  32  write data
- ready_0, ready_1  output  1  request accepted this cycle (combinational)
- rvalid_0, rvalid_1  output  1  read data valid, one-cycle pulse
- rdata_0, rdata_1  output  32  read data
- csb  output  1  chip select to SRAM_interface, active-low
- web  output  1  write enable to SRAM_interface, active-low
- addr  output  9  to SRAM_interface
- addr_2_4  output  2  to SRAM_interface
- addr_3_8  output  3  to SRAM_interface
- conf  output  3  to SRAM_interface
- d_fabric  output  32  write data to SRAM_interface
- d_out  input  32  read data from SRAM_interface

Behaviour:
- Reset (asynchronous, rst_n low):
  - csb = 1, web = 1; addr, addr_2_4, addr_3_8, conf, d_fabric = 0.
  - rvalid_0 = rvalid_1 = 0.
  - Tag pipeline cleared.
  - last_grant = 1, so port 0 wins the first conflict.
- Arbitration (combinational on the current cycle's inputs):
  - If hold = 1: ready_0 = ready_1 = 0.
  - Otherwise, with exactly one valid high, that port is ready.
  - With both valid high, the port not equal to last_grant is ready.
  - At most one ready is ever high.
- Acceptance: valid_x & ready_x at a rising edge.
  - At that edge, register the port's fields onto addr, addr_2_4, addr_3_8, conf and d_fabric.
  - Drive csb = 0 and web = ~we_x.
  - Update last_grant = x.
- No acceptance at an edge: csb = 1 and web = 1 for the next cycle; the other outputs hold their last values.
- Request handshake: a requester keeps valid and all fields stable until ready. The arbiter does not check this.
- Tag pipeline: a READ_LAT-deep shift register of {is_read, port}.
  - Each accepted read enters {1, x}; every other edge enters {0, -}.
- Read return: rvalid_x pulses high for one cycle, starting READ_LAT cycles after the acceptance edge. During that cycle rdata_x = d_out.
  - rdata of the non-returning port = 0.
- Responses have no backpressure; requesters always accept rvalid.
- Writes produce no response.
- Throughput and ordering:
  - Back-to-back acceptances are allowed, one per cycle.
  - Responses return in issue order.
  - A read and a write in consecutive cycles need no stall.
- hold rising mid-stream: no new acceptances. Reads already in the tag pipeline still return normally.
- rst_n low while reads are in flight: all pending rvalid are lost, and no rvalid fires after reset release until new reads are accepted.
- Starvation bound: when both ports stay valid, each is granted at least every second cycle.

Optional Feature:
- SRAM_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins a conflict. last_grant is still updated but ignored by arbitration, and port 1 may starve.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then port 0 writes 0xDEADBEEF to addr 0x05 with conf = 3'b101.
  - Next cycle: csb = 0, web = 0, d_fabric = 0xDEADBEEF.
  - Following cycle: csb = 1.
  - No rvalid.
- Port 1 reads addr 0x05 at edge T (READ_LAT = 3), bench drives d_out = 0xDEADBEEF in cycle T+3.
  - rvalid_1 = 1 and rdata_1 = 0xDEADBEEF exactly in that cycle.
  - rvalid_0 stays 0 throughout.
- Both ports hold reads valid for 4 cycles after reset.
  - Grants alternate 0, 1, 0, 1.
  - rvalid alternates in the same order, READ_LAT cycles later.
- Repeat the previous scenario with SRAM_ARB_FIXED_PRIO_EN defined.
  - ready_0 is high all 4 cycles; ready_1 stays 0.
- hold = 1 for 3 cycles with valid_0 = 1.
  - ready_0 = 0 and csb = 1 throughout.
  - A read accepted the cycle before hold still returns rvalid_0.
- Accept a read, then pull rst_n low for 1 cycle at T+1.
  - All outputs return to reset values immediately.
  - No rvalid for 10 cycles after release.
